mem_block: RTL and testbench
============================

// Module: mem_block
// PURPOSE
//  Packet-addressed memory node on the on-chip packet network.
//  - Accepts 33-bit request packets on a valid/ready input port.
//  - Writes store a 16-bit word.
//  - Reads return a 33-bit response packet to the requesting node on a valid/ready output port.
//  - Sits behind a router port; serves weight/ifmap storage to processing elements.
// PARAMETERS
//  NODE_ID  4'd0  network address of this block; requests to other IDs are rejected
//  DEPTH    256   number of 16-bit words; address field is 8 bits, DEPTH<=256
//  PKT_W    33    packet width; fixed by the network, not to be overridden
// PORTS
//  clk        in   1   single clock, all logic rising-edge
//  rst_n      in   1   asynchronous active-low reset
//  in_valid   in   1   request packet present
//  in_ready   out  1   block can accept a request this cycle
//  in_pkt     in   33  request packet
//  out_valid  out  1   response packet present
//  out_ready  in   1   downstream accepts response this cycle
//  out_pkt    out  33  response packet
//  bad_dest   out  1   sticky: a request with dest!=NODE_ID was received
// BEHAVIOUR
//  Packet layout:
//   [32]    op: 1=write, 0=read (requests) / 0=data (responses)
//   [31:28] src ID   [27:24] dest ID   [23:16] addr   [15:0] data
//  Transfer rule: a transfer occurs on a rising edge with valid&&ready; valid holds until transfer.
//  Reset (async assert, sync release):
//   - out_valid=0, out_pkt=0, bad_dest=0.
//   - All DEPTH words cleared to 0.
//  in_ready = !out_valid || out_ready (single-entry output register; no combinational path in_valid->out_valid).
//  Write accepted (op=1, dest=NODE_ID):
//   - mem[addr] <= data at that edge.
//   - No response packet generated.
//  Read accepted (op=0, dest=NODE_ID):
//   - At the same edge: out_valid<=1, out_pkt<={1'b0, NODE_ID, src, addr, mem[addr]}.
//   - Latency: response visible 1 cycle after acceptance.
//  Back-to-back reads:
//   - With out_ready held high, one response per cycle.
//   - With out_ready low, out_pkt/out_valid hold stable and in_ready=0.
//  Read-after-write, same address, consecutive cycles: read returns the new data (write committed before the read is sampled).
//  Output register release: if out_valid && out_ready and no new read is accepted, out_valid<=0 at that edge.
//  Simultaneous drain and new read: out_pkt is replaced by the new response and out_valid stays 1.
//  Misaddressed request (dest!=NODE_ID): consumed (in_ready per rule above), memory untouched, no response, bad_dest<=1 until reset.
//  addr>=DEPTH:
//   - Write is ignored.
//   - Read returns data=16'h0000 with a normal response.
//  Reset mid-operation: a pending response is discarded; no partial write occurs.
// STRUCTURE
//  Shared package mem_pkg:
//   - typedef struct packed pkt_t {op, src, dest, addr, data}.
//   - Field widths and OP_WRITE/OP_READ constants.
//   - Imported by routers and PEs.
//  Sub-module mem_array: DEPTH x 16 register file with async clear.
//   - Inputs: write enable/address/data.
//   - Combinational read port with write-first forwarding.
//  Top level: request decode, dest check, output register and handshake.
// TESTING
//  1. Reset, then write {1,src=2,dest=0,addr=8'h05,data=16'hBEEF}
//     -> no out_valid; read addr 5 from src=2 -> out_pkt={0,4'h0,4'h2,8'h05,16'hBEEF} one cycle later.
//  2. Read addr 8'h10 immediately after reset -> data=16'h0000.
//  3. Four reads back-to-back with out_ready=1 -> four responses on consecutive cycles, in order.
//  4. Read with out_ready=0 for 5 cycles -> out_pkt stable, in_ready=0; raise out_ready -> one transfer, then out_valid=0.
//  5. Write with dest=4'h3 (NODE_ID=0) -> bad_dest=1, memory unchanged (read returns old value).
//  6. Assert rst_n=0 while out_valid=1 -> out_valid=0 asynchronously; previously written words read back 0.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared packet definitions for the on-chip packet network.
// Used by the memory node, routers and processing elements.
package mem_pkg;

  localparam int OP_W   = 1;
  localparam int ID_W   = 4;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;
  localparam int PKT_W  = OP_W + 2 * ID_W + ADDR_W + DATA_W;

  localparam logic OP_WRITE = 1'b1;
  localparam logic OP_READ  = 1'b0;

  typedef struct packed {
    logic              op;
    logic [ID_W-1:0]   src;
    logic [ID_W-1:0]   dest;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } pkt_t;

  // Build a response packet returned from node to the original requester
  function automatic pkt_t make_resp(input logic [ID_W-1:0]   node,
                                     input logic [ID_W-1:0]   req_src,
                                     input logic [ADDR_W-1:0] addr,
                                     input logic [DATA_W-1:0] data);
    pkt_t p;
    p.op   = OP_READ;
    p.src  = node;
    p.dest = req_src;
    p.addr = addr;
    p.data = data;
    return p;
  endfunction

endpackage

// File: rtl/mem_array.sv
// DEPTH x DATA_W register file with asynchronous clear.
// Combinational read port; a same-cycle write to the read address is
// forwarded so the reader always sees the newest value. Addresses at or
// beyond DEPTH match no word: writes are dropped and reads return zero.
module mem_array
  import mem_pkg::*;
#(
  parameter int DEPTH = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] words [DEPTH];

  for (genvar g = 0; g < DEPTH; g++) begin : g_word
    // Each word clears on reset and loads when its address is written
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        words[g] <= '0;
      end else if (we && (waddr == ADDR_W'(g))) begin
        words[g] <= wdata;
      end
    end
  end

  // Read mux with write-first forwarding; out-of-range reads yield zero
  always_comb begin
    rdata = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (raddr == ADDR_W'(i)) rdata = words[i];
    end
    if (we && (waddr == raddr)) rdata = wdata;
  end

endmodule

// File: rtl/mem_block.sv
// Packet-addressed memory node. Requests arrive on a valid/ready port;
// writes update the array, reads produce one response packet held in a
// single-entry output register. Requests for other node IDs are consumed
// and flagged on the sticky bad_dest output.
module mem_block
  import mem_pkg::*;
#(
  parameter logic [ID_W-1:0] NODE_ID = 4'd0,
  parameter int              DEPTH   = 256,
  parameter int              PKT_W   = 33
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PKT_W-1:0] in_pkt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PKT_W-1:0] out_pkt,
  output logic             bad_dest
);

  pkt_t              req_p0;
  logic              accept_p0;
  logic              hit_p0;
  logic              wr_p0;
  logic              rd_p0;
  logic [DATA_W-1:0] rdata_p0;
  pkt_t              resp_p0;

  pkt_t              resp_p1;
  logic              vld_p1;
  logic              bad_q;

  // ---- stage p0: request decode and array access ----
  assign req_p0    = pkt_t'(in_pkt);
  assign in_ready  = !vld_p1 || out_ready;
  assign accept_p0 = in_valid && in_ready;
  assign hit_p0    = (req_p0.dest == NODE_ID);
  assign wr_p0     = accept_p0 && hit_p0 && (req_p0.op == OP_WRITE);
  assign rd_p0     = accept_p0 && hit_p0 && (req_p0.op == OP_READ);

  mem_array #(
    .DEPTH (DEPTH)
  ) u_array (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wr_p0),
    .waddr (req_p0.addr),
    .wdata (req_p0.data),
    .raddr (req_p0.addr),
    .rdata (rdata_p0)
  );

  assign resp_p0 = make_resp(NODE_ID, req_p0.src, req_p0.addr, rdata_p0);

  // ---- stage p1: output register ----
  // Load on an accepted read, otherwise release once the consumer takes it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      resp_p1 <= '0;
    end else if (rd_p0) begin
      vld_p1  <= 1'b1;
      resp_p1 <= resp_p0;
    end else if (vld_p1 && out_ready) begin
      vld_p1  <= 1'b0;
    end
  end

  // Sticky flag for any consumed request addressed to another node
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bad_q <= 1'b0;
    end else if (accept_p0 && !hit_p0) begin
      bad_q <= 1'b1;
    end
  end

  assign out_valid = vld_p1;
  assign out_pkt   = resp_p1;
  assign bad_dest  = bad_q;

endmodule

// File: tb/tb_mem_block.sv
// Self-checking bench for mem_block: directed scenarios followed by
// randomized traffic, compared against a behavioural model of the node.
module tb_mem_block;

  localparam logic [3:0] NODE = 4'd0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [32:0] in_pkt;
  logic        out_valid;
  logic        out_ready;
  logic [32:0] out_pkt;
  logic        bad_dest;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: memory contents, pending response, sticky flag
  logic [15:0] m_mem [256];
  logic        m_vld;
  logic [32:0] m_pkt;
  logic        m_bad;
  logic        last_acc;

  mem_block #(
    .NODE_ID (NODE),
    .DEPTH   (256),
    .PKT_W   (33)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pkt    (in_pkt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pkt   (out_pkt),
    .bad_dest  (bad_dest)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [32:0] mk(input logic op, input logic [3:0] src,
                                     input logic [3:0] dest, input logic [7:0] addr,
                                     input logic [15:0] data);
    return {op, src, dest, addr, data};
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 256; i++) m_mem[i] = 16'h0;
    m_vld = 1'b0;
    m_pkt = '0;
    m_bad = 1'b0;
  endtask

  // Called just after a falling edge with inputs already driven: check the
  // DUT against the model, advance the model by one rising edge, then move
  // on to the next falling edge.
  task automatic tick();
    logic acc;
    logic [7:0] a;
    #1;
    check("in_ready", 64'(in_ready), 64'(!m_vld || out_ready));
    check("out_valid", 64'(out_valid), 64'(m_vld));
    if (m_vld) check("out_pkt", 64'(out_pkt), 64'(m_pkt));
    check("bad_dest", 64'(bad_dest), 64'(m_bad));
    acc = in_valid && (!m_vld || out_ready);
    last_acc = acc;
    if (m_vld && out_ready) m_vld = 1'b0;
    if (acc) begin
      a = in_pkt[23:16];
      if (in_pkt[27:24] != NODE) begin
        m_bad = 1'b1;
      end else if (in_pkt[32]) begin
        m_mem[a] = in_pkt[15:0];
      end else begin
        m_vld = 1'b1;
        m_pkt = {1'b0, NODE, in_pkt[31:28], a, m_mem[a]};
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [32:0] pend;
    logic        pend_v;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_pkt    = '0;
    out_ready = 1'b1;
    last_acc  = 1'b0;
    model_clear();

    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_pkt", 64'(out_pkt), 64'd0);
    check("rst_bad_dest", 64'(bad_dest), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Scenario 2: read right after reset returns zero data
    in_valid = 1'b1; in_pkt = mk(1'b0, 4'h1, NODE, 8'h10, 16'h0); tick();
    in_valid = 1'b0; tick();
    check("rd_after_rst", 64'(out_pkt), 64'(mk(1'b0, NODE, 4'h1, 8'h10, 16'h0000)));

    // Scenario 1: write then read back, no response to the write
    in_valid = 1'b1; in_pkt = mk(1'b1, 4'h2, NODE, 8'h05, 16'hBEEF); tick();
    check("wr_no_resp", 64'(out_valid), 64'd0);
    in_pkt = mk(1'b0, 4'h2, NODE, 8'h05, 16'h0); tick();
    in_valid = 1'b0; tick();
    check("raw_pkt", 64'(out_pkt), 64'(33'h0_02_05_BEEF));

    // Read immediately after a write to the same address
    in_valid = 1'b1; in_pkt = mk(1'b1, 4'h3, NODE, 8'h22, 16'h1234); tick();
    in_pkt = mk(1'b0, 4'h3, NODE, 8'h22, 16'h0); tick();
    in_valid = 1'b0; tick();
    check("raw_b2b", 64'(out_pkt[15:0]), 64'h1234);

    // Scenario 3: four back-to-back reads with out_ready high
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_pkt = mk(1'b1, 4'h4, NODE, 8'(8'h40 + i), 16'(16'hA000 + i)); tick();
    end
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_pkt = mk(1'b0, 4'(i), NODE, 8'(8'h40 + i), 16'h0); tick();
    end
    in_valid = 1'b0; tick();

    // Scenario 4: stall the response for five cycles, then drain it
    out_ready = 1'b0;
    in_valid = 1'b1; in_pkt = mk(1'b0, 4'h6, NODE, 8'h05, 16'h0); tick();
    in_pkt = mk(1'b0, 4'h7, NODE, 8'h41, 16'h0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_in_ready", 64'(in_ready), 64'd0);
      check("stall_pkt", 64'(out_pkt), 64'(33'h0_06_05_BEEF));
    end
    in_valid = 1'b0; out_ready = 1'b1; tick();
    check("drain_valid", 64'(out_valid), 64'd0);

    // Scenario 5: misaddressed write leaves memory alone and sets the flag
    in_valid = 1'b1; in_pkt = mk(1'b1, 4'h2, 4'h3, 8'h05, 16'hDEAD); tick();
    in_pkt = mk(1'b0, 4'h2, NODE, 8'h05, 16'h0); tick();
    in_valid = 1'b0; tick();
    check("bad_dest_set", 64'(bad_dest), 64'd1);
    check("bad_mem_kept", 64'(out_pkt[15:0]), 64'hBEEF);

    // Scenario 6: asynchronous reset while a response is pending
    in_valid = 1'b1; in_pkt = mk(1'b0, 4'h9, NODE, 8'h22, 16'h0); out_ready = 1'b0; tick();
    in_valid = 1'b0;
    #2;
    check("pre_rst_valid", 64'(out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 64'(out_valid), 64'd0);
    check("async_rst_pkt", 64'(out_pkt), 64'd0);
    check("async_rst_bad", 64'(bad_dest), 64'd0);
    model_clear();
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    in_valid = 1'b1; in_pkt = mk(1'b0, 4'h2, NODE, 8'h05, 16'h0); tick();
    in_valid = 1'b0; tick();
    check("rst_cleared_mem", 64'(out_pkt), 64'(mk(1'b0, NODE, 4'h2, 8'h05, 16'h0000)));

    // Randomized traffic: valid holds its packet until accepted
    pend_v = 1'b0;
    pend   = '0;
    for (int c = 0; c < 600; c++) begin
      if (!pend_v || last_acc) begin
        pend_v = ($urandom_range(0, 3) != 0);
        pend   = mk(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                    ($urandom_range(0, 15) == 0) ? 4'($urandom_range(1, 15)) : NODE,
                    8'($urandom_range(0, 15)), 16'($urandom));
      end
      in_valid  = pend_v;
      in_pkt    = pend;
      out_ready = ($urandom_range(0, 9) < 7);
      tick();
      if (!in_valid) last_acc = 1'b1;
    end
    in_valid = 1'b0; out_ready = 1'b1; tick(); tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
